// File: rtl/slv_guard_multi_chan.sv
// slv_guard_multi_chan
//
// Multi-channel slave guard. It sits between the ID remapper and the
// subordinate on the handshake path only; payloads are muxed outside.
// Outstanding transactions are counted per (channel, remapped ID). Each
// (channel, ID) has a timer that is compared against a per-channel budget.
// A timeout or a spurious completion is a fault. On a fault the guard
// latches the offending (channel, ID), raises a sticky IRQ, isolates the
// subordinate and requests a subordinate reset.
//
// Optional feature, macro SLV_GUARD_ERR_RESP_EN:
//   defined   - after a fault the guard enters ISO. There it answers every
//               outstanding transaction with an injected error response.
//               It then moves to RST.
//   undefined - a fault goes straight to RST. Outstanding transactions are
//               dropped when the counters are cleared in CLR.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   guard_ena_i        enables timer counting and timeout detection
//   budget_i           per-channel timeout in cycles (0 = never times out)
//   mst_req_*          request handshake from the manager side
//   slv_req_*          request handshake to the subordinate
//   slv_rsp_*          response handshake from the subordinate
//                      (last marks the final beat of a transaction)
//   mst_rsp_*          response handshake to the manager side
//                      (err marks a guard-injected error response)
//   irq_o              sticky fault interrupt
//   irq_chan_o         channel of the first fault
//   irq_id_o           ID of the first fault
//   rst_req_o          subordinate reset request
//   rst_stat_i         subordinate reset in progress
module slv_guard_multi_chan #(
  parameter int NumChan      = 2,
  parameter int IdWidth      = 2,
  parameter int MaxTxnsPerId = 4,
  parameter int CntWidth     = 10,
  localparam int NumIds      = 2 ** IdWidth,
  localparam int TxnW        = $clog2(MaxTxnsPerId + 1),
  localparam int ChanW       = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        guard_ena_i,
  input  logic [NumChan*CntWidth-1:0] budget_i,
  input  logic [NumChan-1:0]          mst_req_valid_i,
  output logic [NumChan-1:0]          mst_req_ready_o,
  input  logic [NumChan*IdWidth-1:0]  mst_req_id_i,
  output logic [NumChan-1:0]          slv_req_valid_o,
  input  logic [NumChan-1:0]          slv_req_ready_i,
  input  logic [NumChan-1:0]          slv_rsp_valid_i,
  output logic [NumChan-1:0]          slv_rsp_ready_o,
  input  logic [NumChan*IdWidth-1:0]  slv_rsp_id_i,
  input  logic [NumChan-1:0]          slv_rsp_last_i,
  output logic [NumChan-1:0]          mst_rsp_valid_o,
  input  logic [NumChan-1:0]          mst_rsp_ready_i,
  output logic [NumChan*IdWidth-1:0]  mst_rsp_id_o,
  output logic [NumChan-1:0]          mst_rsp_err_o,
  output logic                        irq_o,
  output logic [ChanW-1:0]            irq_chan_o,
  output logic [IdWidth-1:0]          irq_id_o,
  output logic                        rst_req_o,
  input  logic                        rst_stat_i
);

`ifdef SLV_GUARD_ERR_RESP_EN
  typedef enum logic [1:0] {ST_MON = 2'd0, ST_ISO = 2'd1, ST_RST = 2'd2, ST_CLR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_MON = 2'd0, ST_RST = 2'd2, ST_CLR = 2'd3} state_t;
`endif

  state_t state, state_next;

  logic [TxnW-1:0]     cnt     [NumChan][NumIds];
  logic [CntWidth-1:0] timer   [NumChan][NumIds];
  logic                inc_hit [NumChan][NumIds];
  logic                dec_hit [NumChan][NumIds];
  logic                tmo     [NumChan][NumIds];

  logic [IdWidth-1:0]  req_id [NumChan];
  logic [IdWidth-1:0]  rsp_id [NumChan];
  logic [CntWidth-1:0] budget [NumChan];
  logic                full   [NumChan];
  logic                cpl    [NumChan];

  logic                fault;
  logic [ChanW-1:0]    fault_chan;
  logic [IdWidth-1:0]  fault_id;
  logic                all_zero;

  // Per-channel slices, "full" flag and completion handshake as seen in MON.
  for (genvar g = 0; g < NumChan; g++) begin : g_chan
    assign req_id[g] = mst_req_id_i[g*IdWidth +: IdWidth];
    assign rsp_id[g] = slv_rsp_id_i[g*IdWidth +: IdWidth];
    assign budget[g] = budget_i[g*CntWidth +: CntWidth];
    assign full[g]   = (cnt[g][req_id[g]] == TxnW'(MaxTxnsPerId));
    assign cpl[g]    = slv_rsp_valid_i[g] & mst_rsp_ready_i[g] & slv_rsp_last_i[g];
    for (genvar h = 0; h < NumIds; h++) begin : g_id
      assign tmo[g][h] = guard_ena_i && (budget[g] != '0) && (timer[g][h] >= budget[g]);
    end
  end

  assign rst_req_o = (state == ST_RST);

  // Next-state and handshake steering. In MON the handshakes pass straight
  // through, except that a full (channel, ID) is stalled. Outside MON the
  // request path is closed and the subordinate's responses are sunk.
  // Fault scanning walks from the highest (channel, ID) down, so the
  // lowest channel, then the lowest ID, is the one that ends up latched.
  always_comb begin
    state_next      = state;
    mst_req_ready_o = '0;
    slv_req_valid_o = '0;
    slv_rsp_ready_o = '0;
    mst_rsp_valid_o = '0;
    mst_rsp_id_o    = '0;
    mst_rsp_err_o   = '0;
    fault           = 1'b0;
    fault_chan      = '0;
    fault_id        = '0;
    all_zero        = 1'b1;
    for (int c = 0; c < NumChan; c++) begin
      for (int i = 0; i < NumIds; i++) begin
        inc_hit[c][i] = 1'b0;
        dec_hit[c][i] = 1'b0;
        if (cnt[c][i] != '0) all_zero = 1'b0;
      end
    end

    case (state)
      ST_MON: begin
        for (int c = 0; c < NumChan; c++) begin
          mst_req_ready_o[c] = slv_req_ready_i[c] & ~full[c];
          slv_req_valid_o[c] = mst_req_valid_i[c] & ~full[c];
          mst_rsp_valid_o[c] = slv_rsp_valid_i[c];
          slv_rsp_ready_o[c] = mst_rsp_ready_i[c];
          mst_rsp_id_o[c*IdWidth +: IdWidth] = rsp_id[c];
          inc_hit[c][req_id[c]] = mst_req_valid_i[c] & slv_req_ready_i[c] & ~full[c];
          dec_hit[c][rsp_id[c]] = cpl[c];
        end
        for (int c = NumChan - 1; c >= 0; c--) begin
          for (int i = NumIds - 1; i >= 0; i--) begin
            if (tmo[c][i] || (cpl[c] && (rsp_id[c] == IdWidth'(i)) && (cnt[c][i] == '0))) begin
              fault      = 1'b1;
              fault_chan = ChanW'(c);
              fault_id   = IdWidth'(i);
            end
          end
        end
        if (fault) begin
`ifdef SLV_GUARD_ERR_RESP_EN
          state_next = ST_ISO;
`else
          state_next = ST_RST;
`endif
        end
      end
`ifdef SLV_GUARD_ERR_RESP_EN
      // Each channel answers its lowest outstanding ID with an error response.
      ST_ISO: begin
        slv_rsp_ready_o = '1;
        for (int c = 0; c < NumChan; c++) begin
          for (int i = NumIds - 1; i >= 0; i--) begin
            if (cnt[c][i] != '0) begin
              mst_rsp_valid_o[c] = 1'b1;
              mst_rsp_err_o[c]   = 1'b1;
              mst_rsp_id_o[c*IdWidth +: IdWidth] = IdWidth'(i);
            end
          end
          dec_hit[c][mst_rsp_id_o[c*IdWidth +: IdWidth]] = mst_rsp_valid_o[c] & mst_rsp_ready_i[c];
        end
        if (all_zero) state_next = ST_RST;
      end
`endif
      ST_RST: begin
        slv_rsp_ready_o = '1;
        if (rst_stat_i) state_next = ST_CLR;
      end
      ST_CLR: begin
        slv_rsp_ready_o = '1;
        if (!rst_stat_i) state_next = ST_MON;
      end
      default: state_next = ST_MON;
    endcase
  end

  // State, fault latch, counters and timers. A request and a completion on
  // the same (channel, ID) in one cycle leave the count unchanged. A
  // completion on an empty counter is ignored; MON has already flagged it.
  // A timer restarts when its count leaves zero and on every completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_MON;
      irq_o      <= 1'b0;
      irq_chan_o <= '0;
      irq_id_o   <= '0;
      for (int c = 0; c < NumChan; c++) begin
        for (int i = 0; i < NumIds; i++) begin
          cnt[c][i]   <= '0;
          timer[c][i] <= '0;
        end
      end
    end else begin
      state <= state_next;
      if ((state == ST_MON) && fault) begin
        irq_o      <= 1'b1;
        irq_chan_o <= fault_chan;
        irq_id_o   <= fault_id;
      end
      if ((state == ST_CLR) && !rst_stat_i) begin
        irq_o <= 1'b0;
        for (int c = 0; c < NumChan; c++) begin
          for (int i = 0; i < NumIds; i++) begin
            cnt[c][i]   <= '0;
            timer[c][i] <= '0;
          end
        end
      end else begin
        for (int c = 0; c < NumChan; c++) begin
          for (int i = 0; i < NumIds; i++) begin
            if (inc_hit[c][i] && !(dec_hit[c][i] && (cnt[c][i] != '0))) begin
              cnt[c][i] <= cnt[c][i] + TxnW'(1);
            end else if (!inc_hit[c][i] && dec_hit[c][i] && (cnt[c][i] != '0)) begin
              cnt[c][i] <= cnt[c][i] - TxnW'(1);
            end
            if ((inc_hit[c][i] && (cnt[c][i] == '0)) || dec_hit[c][i]) begin
              timer[c][i] <= '0;
            end else if ((cnt[c][i] != '0) && guard_ena_i && (timer[c][i] != '1)) begin
              timer[c][i] <= timer[c][i] + CntWidth'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_slv_guard_multi_chan.sv
// tb_slv_guard_multi_chan
//
// Directed bench for slv_guard_multi_chan (NumChan=2, IdWidth=2,
// MaxTxnsPerId=4, CntWidth=10). Inputs change on the falling edge and
// outputs are sampled on the falling edge, or 1 time unit after an input
// change for combinational paths. The ISO-dependent expectations follow
// SLV_GUARD_ERR_RESP_EN, so the bench matches whichever build it is
// compiled against.
module tb_slv_guard_multi_chan;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        guard_ena_i = 1'b1;
  logic [19:0] budget_i = '0;
  logic [1:0]  mst_req_valid_i = '0;
  logic [1:0]  mst_req_ready_o;
  logic [3:0]  mst_req_id_i = '0;
  logic [1:0]  slv_req_valid_o;
  logic [1:0]  slv_req_ready_i = 2'b11;
  logic [1:0]  slv_rsp_valid_i = '0;
  logic [1:0]  slv_rsp_ready_o;
  logic [3:0]  slv_rsp_id_i = '0;
  logic [1:0]  slv_rsp_last_i = '0;
  logic [1:0]  mst_rsp_valid_o;
  logic [1:0]  mst_rsp_ready_i = 2'b11;
  logic [3:0]  mst_rsp_id_o;
  logic [1:0]  mst_rsp_err_o;
  logic        irq_o;
  logic [0:0]  irq_chan_o;
  logic [1:0]  irq_id_o;
  logic        rst_req_o;
  logic        rst_stat_i = 1'b0;

  int assert_count = 0;
  int fail_count   = 0;

  slv_guard_multi_chan dut (
    .clk_i(clk_i), .rst_i(rst_i), .guard_ena_i(guard_ena_i), .budget_i(budget_i),
    .mst_req_valid_i(mst_req_valid_i), .mst_req_ready_o(mst_req_ready_o),
    .mst_req_id_i(mst_req_id_i), .slv_req_valid_o(slv_req_valid_o),
    .slv_req_ready_i(slv_req_ready_i), .slv_rsp_valid_i(slv_rsp_valid_i),
    .slv_rsp_ready_o(slv_rsp_ready_o), .slv_rsp_id_i(slv_rsp_id_i),
    .slv_rsp_last_i(slv_rsp_last_i), .mst_rsp_valid_o(mst_rsp_valid_o),
    .mst_rsp_ready_i(mst_rsp_ready_i), .mst_rsp_id_o(mst_rsp_id_o),
    .mst_rsp_err_o(mst_rsp_err_o), .irq_o(irq_o), .irq_chan_o(irq_chan_o),
    .irq_id_o(irq_id_o), .rst_req_o(rst_req_o), .rst_stat_i(rst_stat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  // Drives one set of handshake inputs and lets the combinational paths settle.
  task automatic applyStimulus(input logic [1:0] req_v, input logic [3:0] req_id,
                               input logic [1:0] rsp_v, input logic [3:0] rsp_id,
                               input logic [1:0] rsp_last);
    mst_req_valid_i = req_v;
    mst_req_id_i    = req_id;
    slv_rsp_valid_i = rsp_v;
    slv_rsp_id_i    = rsp_id;
    slv_rsp_last_i  = rsp_last;
    #1;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 4'h0, 2'b00, 4'h0, 2'b00);
  endtask

  task automatic waitIrq(input int max_cycles);
    int n = 0;
    while (!irq_o && n < max_cycles) begin
      tick(1);
      n++;
    end
    checkOutput("irq wait", 32'(irq_o), 32'd1);
  endtask

  // Subordinate reset handshake: rst_stat_i high for 5 cycles, then low.
  task automatic doRecover();
    int n = 0;
    while (!rst_req_o && n < 10) begin
      tick(1);
      n++;
    end
    checkOutput("rst_req wait", 32'(rst_req_o), 32'd1);
    rst_stat_i = 1'b1;
    tick(5);
    checkOutput("rec rst_req low", 32'(rst_req_o), 32'd0);
    rst_stat_i = 1'b0;
    tick(1);
    checkOutput("rec irq clear", 32'(irq_o), 32'd0);
  endtask

  initial begin
    // Reset values
    tick(2);
    rst_i = 1'b0;
    #1;
    checkOutput("rst irq", 32'(irq_o), 32'd0);
    checkOutput("rst irq_chan", 32'(irq_chan_o), 32'd0);
    checkOutput("rst irq_id", 32'(irq_id_o), 32'd0);
    checkOutput("rst rst_req", 32'(rst_req_o), 32'd0);
    checkOutput("rst slv_req_valid", 32'(slv_req_valid_o), 32'd0);
    checkOutput("rst mst_rsp_valid", 32'(mst_rsp_valid_o), 32'd0);

    // Normal transaction: ch0 id2, response after 10 cycles
    budget_i = {10'd50, 10'd50};
    applyStimulus(2'b01, 4'b0010, 2'b00, 4'h0, 2'b00);
    checkOutput("pass slv_req_valid", 32'(slv_req_valid_o), 32'd1);
    checkOutput("pass mst_req_ready", 32'(mst_req_ready_o), 32'd3);
    tick(1);
    idle();
    tick(10);
    applyStimulus(2'b00, 4'h0, 2'b01, 4'b0010, 2'b01);
    checkOutput("pass mst_rsp_valid", 32'(mst_rsp_valid_o), 32'd1);
    checkOutput("pass mst_rsp_id", 32'(mst_rsp_id_o[1:0]), 32'd2);
    checkOutput("pass mst_rsp_err", 32'(mst_rsp_err_o), 32'd0);
    checkOutput("pass slv_rsp_ready", 32'(slv_rsp_ready_o), 32'd3);
    tick(1);
    idle();
    tick(60);
    checkOutput("normal no irq", 32'(irq_o), 32'd0);

    // Outstanding limit on ch0 id0 (ch0 never times out here)
    budget_i = {10'd50, 10'd0};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 4'b0000, 2'b00, 4'h0, 2'b00);
      checkOutput("fill ready", 32'(mst_req_ready_o[0]), 32'd1);
      tick(1);
    end
    applyStimulus(2'b01, 4'b0000, 2'b00, 4'h0, 2'b00);
    checkOutput("full ready", 32'(mst_req_ready_o[0]), 32'd0);
    checkOutput("full slv_valid", 32'(slv_req_valid_o[0]), 32'd0);
    applyStimulus(2'b11, 4'b0000, 2'b00, 4'h0, 2'b00);
    checkOutput("full other chan ready", 32'(mst_req_ready_o), 32'd2);
    checkOutput("full other chan valid", 32'(slv_req_valid_o), 32'd2);
    applyStimulus(2'b01, 4'b0001, 2'b00, 4'h0, 2'b00);
    checkOutput("full other id ready", 32'(mst_req_ready_o[0]), 32'd1);
    applyStimulus(2'b00, 4'h0, 2'b01, 4'b0000, 2'b00);
    tick(1);
    applyStimulus(2'b01, 4'b0000, 2'b00, 4'h0, 2'b00);
    checkOutput("non-last keeps full", 32'(mst_req_ready_o[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 4'h0, 2'b01, 4'b0000, 2'b01);
      tick(1);
    end
    applyStimulus(2'b01, 4'b0000, 2'b00, 4'h0, 2'b00);
    checkOutput("drained ready", 32'(mst_req_ready_o[0]), 32'd1);
    idle();
    checkOutput("drain no irq", 32'(irq_o), 32'd0);

    // Timeout on ch1 id1, budget 20: request handshake at edge 0, irq after edge 21
    budget_i = {10'd20, 10'd0};
    applyStimulus(2'b10, 4'b0100, 2'b00, 4'h0, 2'b00);
    tick(1);
    idle();
    tick(20);
    checkOutput("tmo irq before", 32'(irq_o), 32'd0);
    tick(1);
    checkOutput("tmo irq", 32'(irq_o), 32'd1);
    checkOutput("tmo irq_chan", 32'(irq_chan_o), 32'd1);
    checkOutput("tmo irq_id", 32'(irq_id_o), 32'd1);
`ifdef SLV_GUARD_ERR_RESP_EN
    checkOutput("tmo iso rst_req", 32'(rst_req_o), 32'd0);
    checkOutput("tmo iso valid", 32'(mst_rsp_valid_o), 32'd2);
    checkOutput("tmo iso id", 32'(mst_rsp_id_o[3:2]), 32'd1);
    checkOutput("tmo iso err", 32'(mst_rsp_err_o), 32'd2);
    tick(2);
`endif
    checkOutput("tmo rst_req", 32'(rst_req_o), 32'd1);
    applyStimulus(2'b01, 4'h0, 2'b01, 4'h0, 2'b01);
    checkOutput("rst slv_req blocked", 32'(slv_req_valid_o), 32'd0);
    checkOutput("rst mst_req blocked", 32'(mst_req_ready_o), 32'd0);
    checkOutput("rst rsp blocked", 32'(mst_rsp_valid_o), 32'd0);
    checkOutput("rst rsp sunk", 32'(slv_rsp_ready_o), 32'd3);
    idle();

    // Recovery with guard disabled: fault progress must not depend on it
    guard_ena_i = 1'b0;
    rst_stat_i = 1'b1;
    tick(1);
    checkOutput("clr rst_req", 32'(rst_req_o), 32'd0);
    checkOutput("clr irq held", 32'(irq_o), 32'd1);
    tick(4);
    rst_stat_i = 1'b0;
    #1;
    checkOutput("clr irq before", 32'(irq_o), 32'd1);
    tick(1);
    checkOutput("mon irq cleared", 32'(irq_o), 32'd0);
    guard_ena_i = 1'b1;
    applyStimulus(2'b01, 4'h0, 2'b00, 4'h0, 2'b00);
    checkOutput("mon pass again", 32'(slv_req_valid_o), 32'd1);
    idle();
    tick(25);
    checkOutput("cleared no tmo", 32'(irq_o), 32'd0);

    // Spurious completion on ch1 id2 with guard disabled
    guard_ena_i = 1'b0;
    applyStimulus(2'b00, 4'h0, 2'b10, 4'b1000, 2'b10);
    checkOutput("spur pass valid", 32'(mst_rsp_valid_o), 32'd2);
    tick(1);
    idle();
    checkOutput("spur irq", 32'(irq_o), 32'd1);
    checkOutput("spur irq_chan", 32'(irq_chan_o), 32'd1);
    checkOutput("spur irq_id", 32'(irq_id_o), 32'd2);
    doRecover();
    guard_ena_i = 1'b1;

    // Three outstanding on ch0 id3, timeout
    budget_i = {10'd0, 10'd10};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 4'b0011, 2'b00, 4'h0, 2'b00);
      tick(1);
    end
    idle();
    waitIrq(40);
    checkOutput("multi irq_chan", 32'(irq_chan_o), 32'd0);
    checkOutput("multi irq_id", 32'(irq_id_o), 32'd3);
`ifdef SLV_GUARD_ERR_RESP_EN
    mst_rsp_ready_i = 2'b00;
    tick(1);
    checkOutput("inj hold valid", 32'(mst_rsp_valid_o[0]), 32'd1);
    mst_rsp_ready_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("inj valid", 32'(mst_rsp_valid_o[0]), 32'd1);
      checkOutput("inj id", 32'(mst_rsp_id_o[1:0]), 32'd3);
      checkOutput("inj err", 32'(mst_rsp_err_o[0]), 32'd1);
      checkOutput("inj rst_req low", 32'(rst_req_o), 32'd0);
      tick(1);
    end
    checkOutput("inj done valid", 32'(mst_rsp_valid_o[0]), 32'd0);
    tick(1);
    checkOutput("inj then rst_req", 32'(rst_req_o), 32'd1);
`else
    checkOutput("multi rst_req", 32'(rst_req_o), 32'd1);
    checkOutput("multi no rsp", 32'(mst_rsp_valid_o), 32'd0);
`endif
    doRecover();
    tick(20);
    checkOutput("multi dropped", 32'(irq_o), 32'd0);

    // Simultaneous timeouts ch0 id3 and ch1 id0, then reset mid-fault
    budget_i = {10'd20, 10'd20};
    applyStimulus(2'b11, 4'b0011, 2'b00, 4'h0, 2'b00);
    tick(1);
    idle();
    waitIrq(40);
    checkOutput("sim irq_chan", 32'(irq_chan_o), 32'd0);
    checkOutput("sim irq_id", 32'(irq_id_o), 32'd3);
`ifdef SLV_GUARD_ERR_RESP_EN
    mst_rsp_ready_i = 2'b00;
    #1;
    checkOutput("sim inj both", 32'(mst_rsp_valid_o), 32'd3);
    checkOutput("sim inj ids", 32'(mst_rsp_id_o), 32'h3);
    mst_rsp_ready_i = 2'b11;
`endif
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    #1;
    checkOutput("mid rst irq", 32'(irq_o), 32'd0);
    checkOutput("mid rst irq_id", 32'(irq_id_o), 32'd0);
    checkOutput("mid rst rst_req", 32'(rst_req_o), 32'd0);
    checkOutput("mid rst rsp valid", 32'(mst_rsp_valid_o), 32'd0);
    tick(25);
    checkOutput("mid rst forgotten", 32'(irq_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
